// File: rtl/softcore_pkg.sv
// Shared definitions for the softcore register-file control path:
// opcodes, sequencer FSM encoding, constant selects and register count.
package softcore_pkg;

  // Number of writable registers (selects 0..NUM_REGS-1).
  localparam int NUM_REGS = 4;

  // Opcode map; 9..15 are illegal.
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;
  localparam logic [3:0] OP_RD  = 4'd8;

  // Read-only constant selects served by the register file.
  localparam logic [3:0] SEL_CONST_00 = 4'h8;
  localparam logic [3:0] SEL_CONST_01 = 4'h9;
  localparam logic [3:0] SEL_CONST_FF = 4'hA;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_CAP  = 3'd3,
    ST_WR   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  // True for the two-operand ops that update the flags.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

endpackage

// File: rtl/reg_op_alu.sv
// Combinational ALU for the sequencer: ADD/SUB/AND/OR/XOR on A and B,
// with B passed through for every other op (MOV, RD).
module reg_op_alu
  import softcore_pkg::*;
#(
  parameter int REG_WIDTH = 8
) (
  input  logic [3:0]           op,
  input  logic [REG_WIDTH-1:0] a,
  input  logic [REG_WIDTH-1:0] b,
  output logic [REG_WIDTH-1:0] result,
  output logic                 zero,
  output logic                 carry
);

  logic [REG_WIDTH:0] sum;
  logic [REG_WIDTH:0] diff;

  // One extra bit so the MSB is carry for ADD and borrow for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Operation select; logic ops clear carry.
  always_comb begin
    result = b;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[REG_WIDTH-1:0];
        carry  = sum[REG_WIDTH];
      end
      OP_SUB: begin
        result = diff[REG_WIDTH-1:0];
        carry  = diff[REG_WIDTH];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/reg_op_sequencer.sv
// Register-file access sequencer: accepts one decoded instruction, walks
// read A / read B / compute / write-back against a register file with a
// one-cycle registered read, and reports completion, result and flags.
module reg_op_sequencer
  import softcore_pkg::*;
#(
  parameter int SELECT_WIDTH = 4,
  parameter int REG_WIDTH    = 8,
  parameter int NUM_REGS     = softcore_pkg::NUM_REGS
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_instValid,
  output logic                    o_instReady,
  input  logic [3:0]              i_opcode,
  input  logic [SELECT_WIDTH-1:0] i_dstSel,
  input  logic [SELECT_WIDTH-1:0] i_srcSel,
  input  logic [REG_WIDTH-1:0]    i_imm,
  output logic                    o_rfLdSig,
  output logic [SELECT_WIDTH-1:0] o_rfSel,
  output logic [REG_WIDTH-1:0]    o_rfData,
  input  logic [REG_WIDTH-1:0]    i_rfData,
  output logic                    o_done,
  output logic                    o_err,
  output logic [REG_WIDTH-1:0]    o_result,
  output logic                    o_zero,
  output logic                    o_carry,
  output logic                    o_busy
);

  state_t state_reg;
  state_t state_next;

  logic [3:0]              op_reg;
  logic [SELECT_WIDTH-1:0] dst_reg;
  logic [SELECT_WIDTH-1:0] src_reg;
  logic [REG_WIDTH-1:0]    imm_reg;
  logic [REG_WIDTH-1:0]    a_reg;
  logic [REG_WIDTH-1:0]    calc_reg;
  logic [REG_WIDTH-1:0]    result_reg;
  logic                    zero_reg;
  logic                    carry_reg;
  logic                    err_reg;

  logic                    accept;
  logic                    illegal_in;
  logic [REG_WIDTH-1:0]    alu_result;
  logic                    alu_zero;
  logic                    alu_carry;
  logic [REG_WIDTH-1:0]    wr_data;

  // B is whatever the register file returns during CAP.
  reg_op_alu #(
    .REG_WIDTH(REG_WIDTH)
  ) u_alu (
    .op    (op_reg),
    .a     (a_reg),
    .b     (i_rfData),
    .result(alu_result),
    .zero  (alu_zero),
    .carry (alu_carry)
  );

  assign accept = i_instValid && (state_reg == ST_IDLE);

  // Illegal opcode, or a writing op aimed at a constant / unmapped select.
  assign illegal_in = (i_opcode > OP_RD) ||
                      ((i_opcode >= OP_LDI) && (i_opcode <= OP_XOR) &&
                       (int'(i_dstSel) >= NUM_REGS));

  assign wr_data = (op_reg == OP_LDI) ? imm_reg : calc_reg;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode and register-file port drive.
  always_comb begin
    state_next = state_reg;
    o_rfLdSig  = 1'b0;
    o_rfSel    = '0;
    o_rfData   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (i_instValid) begin
          if (illegal_in) begin
            state_next = ST_DONE;
          end else begin
            case (i_opcode)
              OP_NOP:         state_next = ST_DONE;
              OP_LDI:         state_next = ST_WR;
              OP_MOV, OP_RD:  state_next = ST_RD_B;
              default:        state_next = ST_RD_A;
            endcase
          end
        end
      end
      ST_RD_A: begin
        o_rfSel    = dst_reg;
        state_next = ST_RD_B;
      end
      ST_RD_B: begin
        o_rfSel    = src_reg;
        state_next = ST_CAP;
      end
      ST_CAP: begin
        o_rfSel    = src_reg;
        state_next = (op_reg == OP_RD) ? ST_DONE : ST_WR;
      end
      ST_WR: begin
        o_rfLdSig  = 1'b1;
        o_rfSel    = dst_reg;
        o_rfData   = wr_data;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Instruction latch, operand capture, result and flag registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_reg     <= '0;
      dst_reg    <= '0;
      src_reg    <= '0;
      imm_reg    <= '0;
      a_reg      <= '0;
      calc_reg   <= '0;
      result_reg <= '0;
      zero_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        op_reg  <= i_opcode;
        dst_reg <= i_dstSel;
        src_reg <= i_srcSel;
        imm_reg <= i_imm;
        err_reg <= illegal_in;
      end
      // Data for the RD_A select arrives during RD_B.
      if (state_reg == ST_RD_B) begin
        a_reg <= i_rfData;
      end
      if (state_reg == ST_CAP) begin
        calc_reg <= alu_result;
        if (is_alu_op(op_reg)) begin
          zero_reg  <= alu_zero;
          carry_reg <= alu_carry;
        end
        // RD skips write-back, so its result is published straight from CAP.
        if (op_reg == OP_RD) begin
          result_reg <= alu_result;
        end
      end
      if (state_reg == ST_WR) begin
        result_reg <= wr_data;
      end
    end
  end

  assign o_instReady = (state_reg == ST_IDLE);
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_done      = (state_reg == ST_DONE);
  assign o_err       = (state_reg == ST_DONE) && err_reg;
  assign o_result    = result_reg;
  assign o_zero      = zero_reg;
  assign o_carry     = carry_reg;

endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
Control stage that sits directly upstream of the softcore register file and is the only block driving its load, select and data-in ports.
Accepts one decoded instruction at a time over a valid/ready handshake and runs the multi-cycle register-file access sequence: read operand A, read operand B, ALU compute, write-back.
Honours the register file's registered read (select in cycle N, data valid in cycle N+1) and its constant selects (0x8 reads 0x00, 0x9 reads 0x01, 0xA reads 0xFF).
Reports completion, result and flags to the control unit.

Parameters:
SELECT_WIDTH, 4, width of register select; matches the register file.
REG_WIDTH, 8, datapath width; matches the register file.
NUM_REGS, 4, writable registers at selects 0..NUM_REGS-1.

Ports:
i_clk  in  1  clock; all logic on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_instValid  in  1  instruction offered.
o_instReady  out  1  high only in IDLE; accept = i_instValid & o_instReady at a rising edge.
i_opcode  in  4  operation code.
i_dstSel  in  SELECT_WIDTH  destination select; also operand A.
i_srcSel  in  SELECT_WIDTH  operand B select; may be a constant select.
i_imm  in  REG_WIDTH  immediate for LDI.
o_rfLdSig  out  1  to register file i_ldSig.
o_rfSel  out  SELECT_WIDTH  to register file i_regSel.
o_rfData  out  REG_WIDTH  to register file i_regData.
i_rfData  in  REG_WIDTH  from register file o_regData.
o_done  out  1  one-cycle completion pulse.
o_err  out  1  one-cycle pulse, coincident with o_done, for illegal instructions.
o_result  out  REG_WIDTH  last result; held until the next completion.
o_zero  out  1  result == 0; updated by ALU ops only.
o_carry  out  1  ADD carry-out or SUB borrow (A<B); 0 for logic ops; ALU ops only.
o_busy  out  1  inverse of o_instReady.

Behaviour:
- Reset state: IDLE. All outputs 0 except o_instReady = 1. Operand/result registers cleared.
- Opcodes:
  - 0 NOP.
  - 1 LDI: dst <= imm.
  - 2 MOV: dst <= src.
  - 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR: dst <= dst op src.
  - 8 RD: o_result <= src; no write.
  - 9..15 illegal.
- Illegal conditions: an illegal opcode, or dst >= NUM_REGS for any writing op (1..7). Either goes straight to DONE with o_err = 1, no register-file write, flags untouched.
- FSM states: IDLE, RD_A, RD_B, CAP, WR, DONE. Instruction fields are latched on accept.
- Per-state outputs:
  - RD_A: ld = 0, sel = dst.
  - RD_B: ld = 0, sel = src; A captured from i_rfData at the end of this cycle.
  - CAP: ld = 0, sel = src; i_rfData is B; result and flags registered at the end of this cycle.
  - WR: ld = 1, sel = dst, data = result.
  - DONE: o_done = 1; o_result valid from this cycle onward.
  - IDLE: ld = 0, sel = 0.
- Sequences after the accept edge:
  - ALU: RD_A, RD_B, CAP, WR, DONE. o_done in cycle 5.
  - MOV: RD_B, CAP, WR, DONE. Cycle 4.
  - RD: RD_B, CAP, DONE. Cycle 3.
  - LDI: WR, DONE. Cycle 2.
  - NOP or illegal: DONE. Cycle 1.
- DONE always returns to IDLE, so there is at least one ready cycle between instructions. i_instValid while busy is ignored; fields are not re-sampled.
- Arithmetic: ADD and SUB use REG_WIDTH+1-bit intermediates; results wrap modulo 2^REG_WIDTH. The MSB of ADD is carry; the MSB of SUB is borrow.
- dst == src is legal; A and B are read in separate cycles and equal the same value.
- Constant selects are legal as src for every op.
- Reset in any state, including WR: the next cycle is IDLE with ld = 0. The pending instruction is dropped with no o_done. A write already committed at an earlier edge stands.
- o_rfLdSig is high only in WR, never for more than one cycle per instruction.

Decomposition:
- Shared package softcore_pkg holds: the opcode constants, the FSM state encoding, the constant-select values (0x8/0x9/0xA), and NUM_REGS.
- One combinational sub-module, reg_op_alu: inputs op, A, B; outputs result, zero, carry. Covers the ADD..XOR and MOV/RD pass-through.

Test Plan:
- Reset, then LDI dst=1 imm=0x3C → cycle 1 shows ld=1, sel=1, data=0x3C; o_done in cycle 2; register 1 reads 0x3C; flags remain 0.
- With r1=0xF0 and r2=0x20: ADD dst=1 src=2 → o_done 5 cycles after accept; r1=0x10, o_result=0x10, carry=1, zero=0.
- XOR dst=1 src=1 (r1=0x10) → r1=0x00, zero=1, carry=0. Then SUB dst=1 src=0x9 → r1=0xFF, carry=1.
- MOV dst=3 src=0xA → r3=0xFF, o_done in cycle 4. Then RD src=3 → o_result=0xFF in cycle 3 with ld never asserted.
- Illegal cases: opcode 0xC, and LDI dst=0x8 → o_done and o_err both in cycle 1; ld stays 0; all registers and flags unchanged.
- Reset asserted during CAP of ADD dst=2 → no WR, no o_done; o_instReady=1 in the first cycle after reset deasserts. A valid held high through a busy period is accepted only once IDLE is reached.
